// File: rtl/gnr_pkg.sv
// Shared types for the Boolean-network attractor controller.
// Optional GNR_PERIOD_EN adds a period-measurement state.
package gnr_pkg;

    localparam int CNT_W_DEF = 16;

    // Step counts are compared only when this bit is clear (even count)
    localparam int EVEN_BIT = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_CMP,
        S_PERIOD,
        S_DONE
    } state_t;

endpackage

// File: rtl/gnr_period_meter.sv
// Pulse counter and s1 vs attractor compare for period measurement.
// Present only when GNR_PERIOD_EN is defined.
`ifdef GNR_PERIOD_EN
module gnr_period_meter
    import gnr_pkg::*;
#(
    parameter int N_NODES = 8,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               pulse,
    input  logic [N_NODES-1:0] s1_vec,
    input  logic [N_NODES-1:0] ref_vec,
    output logic [CNT_W-1:0]   count,
    output logic               equal
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (pulse && count != {CNT_W{1'b1}}) begin
            count <= count + 1'b1;
        end
    end

    assign equal = (s1_vec == ref_vec);

endmodule
`endif

// File: rtl/gnr_attractor_ctrl.sv
// Floyd attractor search over an array of two-copy Boolean-network nodes.
// Define GNR_PERIOD_EN to also measure the attractor period after a meet.
module gnr_attractor_ctrl
    import gnr_pkg::*;
#(
    parameter int               N_NODES   = 8,
    parameter int               CNT_W     = CNT_W_DEF,
    parameter logic [CNT_W-1:0] MAX_STEPS = {CNT_W{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [N_NODES-1:0] attr_vec,
    output logic [CNT_W-1:0]   step_cnt,
    output logic [CNT_W-1:0]   period,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             even_ok;
    logic             meet;

    // Odd counts always compare equal, so only even counts >= 2 count
    assign even_ok = !cnt[EVEN_BIT] && (cnt != '0);
    assign meet    = even_ok && (s0_vec == s1_vec);

`ifdef GNR_PERIOD_EN
    logic             ph;
    logic             p_eq;
    logic [CNT_W-1:0] p_cnt;
    logic [CNT_W-1:0] period_q;

    gnr_period_meter #(
        .N_NODES(N_NODES),
        .CNT_W  (CNT_W)
    ) u_meter (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == S_CMP),
        .pulse  (start_s1 && state == S_PERIOD),
        .s1_vec (s1_vec),
        .ref_vec(attr_vec),
        .count  (p_cnt),
        .equal  (p_eq)
    );

    assign period = period_q;
`else
    assign period = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            attr_vec   <= '0;
            step_cnt   <= '0;
            reset_nos  <= 1'b0;
            init_state <= '0;
            start_s0   <= 1'b0;
            start_s1   <= 1'b0;
`ifdef GNR_PERIOD_EN
            ph         <= 1'b0;
            period_q   <= '0;
`endif
        end else begin
            done      <= 1'b0;
            reset_nos <= 1'b0;
            start_s0  <= 1'b0;
            start_s1  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        init_state <= init_vec;
                        cnt        <= '0;
                        timeout    <= 1'b0;
                        busy       <= 1'b1;
                        reset_nos  <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    start_s0 <= 1'b1;
                    start_s1 <= 1'b1;
                    state    <= S_STEP;
                end
                S_STEP: begin
                    if (cnt != MAX_STEPS) begin
                        cnt <= cnt + 1'b1;
                    end
                    state <= S_CMP;
                end
                S_CMP: begin
                    if (meet) begin
                        attr_vec <= s1_vec;
                        step_cnt <= cnt;
`ifdef GNR_PERIOD_EN
                        start_s1 <= 1'b1;
                        ph       <= 1'b0;
                        state    <= S_PERIOD;
`else
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
`endif
                    end else if (cnt == MAX_STEPS) begin
                        timeout  <= 1'b1;
                        step_cnt <= cnt;
                        attr_vec <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        start_s0 <= 1'b1;
                        start_s1 <= 1'b1;
                        state    <= S_STEP;
                    end
                end
`ifdef GNR_PERIOD_EN
                S_PERIOD: begin
                    if (!ph) begin
                        ph <= 1'b1;
                    end else if (p_eq) begin
                        period_q <= p_cnt;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else if (p_cnt == MAX_STEPS) begin
                        timeout  <= 1'b1;
                        period_q <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        start_s1 <= 1'b1;
                        ph       <= 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
